// File: rtl/uart_rx_cfg_if.sv
// Receive-FIFO read port of uart_rx_cfg: show-ahead head entry plus pop handshake.
interface uart_rx_cfg_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    rx_data;
  logic          rx_perr;
  logic          rx_ferr;
  logic          rx_brk;
  logic          rx_valid;
  logic          rx_ready;
  logic [LW-1:0] level;

  modport master (
    output rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, level,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_perr, rx_ferr, rx_brk, rx_valid, level,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 16x oversampling, 3-sample majority vote, 5-8 data bits,
// optional parity, 1/2 stop bits, break detection, show-ahead FIFO with per-byte flags.
//   state     | meaning
//   S_IDLE    | waiting for a low on the synchronised line
//   S_START   | start bit; a high vote at tick 9 is a false start
//   S_DATA    | data bits, LSB first
//   S_PARITY  | parity bit, checked at tick 9
//   S_STOP    | stop bit(s); entry pushed at tick 9 of the last one
//   S_BRKWAIT | break received, waiting for the line to return high
module uart_rx_cfg #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_rx,
  input  logic             i_rx_en,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic [1:0]       i_cfg_data_bits,
  input  logic [1:0]       i_cfg_parity,
  input  logic             i_cfg_stop2,
  input  logic             i_err_clr,
  output logic             o_err_overrun,
  output logic             o_busy,
  uart_rx_cfg_if.master    rx_if
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rx_meta, r_rx_sync;
  logic [DIV_W-1:0] r_div_cnt, r_cfg_div;
  logic [1:0]       r_cfg_data_bits, r_cfg_parity;
  logic             r_cfg_stop2;
  logic [3:0]       r_os_cnt;
  logic [2:0]       r_nbit;
  logic [7:0]       r_data;
  logic             r_s7, r_s8, r_pbit, r_perr, r_ferr, r_stop_idx;

  logic             w_rs, w_tick, w_t9, w_t15, w_vote, w_par_en, w_brk;
  logic             w_start, w_push;
  logic [10:0]      w_entry;

  logic [10:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_err_ovf;
  logic             w_full, w_pop, w_wr, w_ovf;
  logic [10:0]      w_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_rs     = r_rx_sync;
  assign w_tick   = (r_div_cnt == r_cfg_div);
  assign w_t9     = w_tick && (r_os_cnt == 4'd9);
  assign w_t15    = w_tick && (r_os_cnt == 4'd15);
  assign w_vote   = (r_s7 & r_s8) | (r_s7 & w_rs) | (r_s8 & w_rs);
  assign w_par_en = (r_cfg_parity == 2'b01) || (r_cfg_parity == 2'b10);
  // r_pbit stays 0 when parity is off, so it only vetoes a break when a parity bit was high
  assign w_brk    = (r_data == 8'h00) && !r_pbit && !w_vote;
  assign w_entry  = {w_brk, r_ferr | ~w_vote, r_perr & ~w_brk, r_data};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rs) begin
          w_state_nxt = S_START;
          w_start     = 1'b1;
        end
      end
      S_START: begin
        if (w_t9 && w_vote)  w_state_nxt = S_IDLE;
        else if (w_t15)      w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_t15 && (r_nbit == {1'b1, r_cfg_data_bits}))
          w_state_nxt = w_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_t15) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_t9 && (r_stop_idx == r_cfg_stop2)) begin
          w_push      = 1'b1;
          w_state_nxt = w_brk ? S_BRKWAIT : S_IDLE;
        end
      end
      S_BRKWAIT: begin
        if (w_rs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!i_rx_en) begin
      w_state_nxt = S_IDLE;
      w_start     = 1'b0;
      w_push      = 1'b0;
    end
  end

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt <= '0;
    end else if (w_start || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cfg_div       <= '0;
      r_cfg_data_bits <= '0;
      r_cfg_parity    <= '0;
      r_cfg_stop2     <= 1'b0;
      r_os_cnt        <= '0;
      r_nbit          <= '0;
      r_data          <= '0;
      r_s7            <= 1'b1;
      r_s8            <= 1'b1;
      r_pbit          <= 1'b0;
      r_perr          <= 1'b0;
      r_ferr          <= 1'b0;
      r_stop_idx      <= 1'b0;
    end else if (w_start) begin
      r_cfg_div       <= i_cfg_div;
      r_cfg_data_bits <= i_cfg_data_bits;
      r_cfg_parity    <= i_cfg_parity;
      r_cfg_stop2     <= i_cfg_stop2;
      r_os_cnt        <= '0;
      r_nbit          <= '0;
      r_data          <= '0;
      r_pbit          <= 1'b0;
      r_perr          <= 1'b0;
      r_ferr          <= 1'b0;
      r_stop_idx      <= 1'b0;
    end else if (w_tick && (r_state != S_IDLE)) begin
      r_os_cnt <= r_os_cnt + 4'd1;
      if (r_os_cnt == 4'd7) r_s7 <= w_rs;
      if (r_os_cnt == 4'd8) r_s8 <= w_rs;
      if (w_t9) begin
        case (r_state)
          S_DATA:   r_data[r_nbit] <= w_vote;
          S_PARITY: begin
            r_pbit <= w_vote;
            r_perr <= ^r_data ^ w_vote ^ (r_cfg_parity == 2'b10);
          end
          S_STOP:   if (!w_vote) r_ferr <= 1'b1;
          default:  ;
        endcase
      end
      if (w_t15) begin
        if (r_state == S_DATA) r_nbit     <= r_nbit + 3'd1;
        if (r_state == S_STOP) r_stop_idx <= 1'b1;
      end
    end
  end

  assign w_full = (r_level == LW'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) && rx_if.rx_ready;
  // at full, a same-cycle pop frees the slot the push needs
  assign w_wr   = w_push && (!w_full || w_pop);
  assign w_ovf  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      r_err_ovf <= w_ovf | (r_err_ovf & ~i_err_clr);
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign rx_if.rx_valid = (r_level != '0);
  assign rx_if.rx_data  = rx_if.rx_valid ? w_head[7:0] : 8'h00;
  assign rx_if.rx_perr  = rx_if.rx_valid & w_head[8];
  assign rx_if.rx_ferr  = rx_if.rx_valid & w_head[9];
  assign rx_if.rx_brk   = rx_if.rx_valid & w_head[10];
  assign rx_if.level    = r_level;
  assign o_err_overrun  = r_err_ovf;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frame-format vector table plus sequences for
// push latency, glitch, break, enable drop, overrun and mid-frame reset.
module tb_uart_rx_cfg;
  localparam int DEPTH = 4;
  localparam int DIV   = 3;
  localparam int BITC  = 16 * (DIV + 1);

  logic        clk = 1'b0;
  logic        resetn, rx, rx_en, cfg_s2, err_clr, err_overrun, busy;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_db, cfg_par;
  int          checks = 0;
  int          errors = 0;

  uart_rx_cfg_if #(.FIFO_DEPTH(DEPTH)) rif ();

  uart_rx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .i_rx            (rx),
    .i_rx_en         (rx_en),
    .i_cfg_div       (cfg_div),
    .i_cfg_data_bits (cfg_db),
    .i_cfg_parity    (cfg_par),
    .i_cfg_stop2     (cfg_s2),
    .i_err_clr       (err_clr),
    .o_err_overrun   (err_overrun),
    .o_busy          (busy),
    .rx_if           (rif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] db;
    logic [1:0] par;
    logic       s2;
    logic [7:0] d;
    logic       flip;
    logic [1:0] stops;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rx = b;
    repeat (BITC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] db, input logic [1:0] par, input logic s2,
                            input logic [7:0] d, input logic flip, input logic [1:0] stops);
    int   nb;
    logic p;
    nb      = 5 + int'(db);
    cfg_db  = db;
    cfg_par = par;
    cfg_s2  = s2;
    p       = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    if (par == 2'b10) p = ~p;
    p = p ^ flip;
    bit_out(1'b0);
    for (int i = 0; i < nb; i++) bit_out(d[i]);
    if (par == 2'b01 || par == 2'b10) bit_out(p);
    bit_out(stops[0]);
    if (s2) bit_out(stops[1]);
    rx = 1'b1;
    repeat (80) @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!rif.rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rif.rx_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout rx_valid actual=0 required=1", nm);
    end
  endtask

  task automatic chk_head(input string nm, input logic [7:0] d, input logic p,
                          input logic f, input logic b);
    chk({nm, ".data"}, 32'(rif.rx_data), 32'(d));
    chk({nm, ".perr"}, 32'(rif.rx_perr), 32'(p));
    chk({nm, ".ferr"}, 32'(rif.rx_ferr), 32'(f));
    chk({nm, ".brk"},  32'(rif.rx_brk),  32'(b));
  endtask

  task automatic pop();
    rif.rx_ready = 1'b1;
    @(negedge clk);
    rif.rx_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk_head(nm, 8'h00, 1'b0, 1'b0, 1'b0);
    chk({nm, ".valid"},   32'(rif.rx_valid), 32'd0);
    chk({nm, ".level"},   32'(rif.level),    32'd0);
    chk({nm, ".overrun"}, 32'(err_overrun),  32'd0);
    chk({nm, ".busy"},    32'(busy),         32'd0);
  endtask

  initial begin
    //        db     par    s2    d      flip  stops  ed     ep    ef
    vecs[0] = '{2'd3, 2'b00, 1'b0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 2'b01, 1'b1, 8'h3C, 1'b0, 2'b11, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 2'b01, 1'b1, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{2'd3, 2'b10, 1'b0, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 2'b10, 1'b0, 8'h5A, 1'b1, 2'b11, 8'h5A, 1'b1, 1'b0};
    vecs[5] = '{2'd1, 2'b00, 1'b1, 8'h2B, 1'b0, 2'b11, 8'h2B, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 2'b11, 1'b0, 8'hFF, 1'b0, 2'b11, 8'h3F, 1'b0, 1'b0};
    vecs[7] = '{2'd0, 2'b01, 1'b0, 8'h1F, 1'b0, 2'b10, 8'h1F, 1'b0, 1'b1};
    vecs[8] = '{2'd3, 2'b11, 1'b1, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1};
    vecs[9] = '{2'd2, 2'b00, 1'b1, 8'h41, 1'b0, 2'b00, 8'h41, 1'b0, 1'b1};

    resetn = 1'b0; rx = 1'b1; rx_en = 1'b1; err_clr = 1'b0; rif.rx_ready = 1'b0;
    cfg_div = 16'(DIV); cfg_db = 2'd3; cfg_par = 2'b00; cfg_s2 = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5: push edge is the 619th posedge after rx falls
    fork
      send_frame(2'd3, 2'b00, 1'b0, 8'hA5, 1'b0, 2'b11);
      begin
        repeat (618) @(posedge clk);
        @(negedge clk);
        chk("lat_before", 32'(rif.rx_valid), 32'd0);
        @(negedge clk);
        chk("lat_after", 32'(rif.rx_valid), 32'd1);
        chk("lat_level", 32'(rif.level), 32'd1);
      end
    join
    chk_head("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    pop();
    chk("a5_pop_level", 32'(rif.level), 32'd0);

    for (int v = 0; v < 10; v++) begin
      send_frame(vecs[v].db, vecs[v].par, vecs[v].s2, vecs[v].d, vecs[v].flip, vecs[v].stops);
      wait_valid($sformatf("vec%0d", v));
      chk_head($sformatf("vec%0d", v), vecs[v].ed, vecs[v].ep, vecs[v].ef, 1'b0);
      chk($sformatf("vec%0d.level", v), 32'(rif.level), 32'd1);
      pop();
      chk($sformatf("vec%0d.pop_level", v), 32'(rif.level), 32'd0);
    end

    // glitch of 5 ticks: false start
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (80) @(negedge clk);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_level", 32'(rif.level), 32'd0);

    // 5N1 0x1F with low stop bit, then line held low -> one break entry
    cfg_db = 2'd0; cfg_par = 2'b00; cfg_s2 = 1'b0;
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(1'b1);
    rx = 1'b0;
    repeat (2 * 7 * BITC + BITC) @(negedge clk);
    chk("brk_level_low", 32'(rif.level), 32'd2);
    chk("brk_busy_low", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("brk_busy_high", 32'(busy), 32'd0);
    chk("brk_level_high", 32'(rif.level), 32'd2);
    chk_head("brk_e1", 8'h1F, 1'b0, 1'b1, 1'b0);
    pop();
    chk_head("brk_e2", 8'h00, 1'b0, 1'b1, 1'b1);
    pop();
    chk("brk_pop_level", 32'(rif.level), 32'd0);

    // receiver disabled mid-DATA
    fork
      send_frame(2'd3, 2'b00, 1'b0, 8'hFF, 1'b0, 2'b11);
      begin
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("en_busy_data", 32'(busy), 32'd1);
        rx_en = 1'b0;
        @(negedge clk);
        chk("en_busy_off", 32'(busy), 32'd0);
      end
    join
    chk("en_level", 32'(rif.level), 32'd0);
    rx_en = 1'b1;

    // overrun: five bytes into a four-deep FIFO
    send_frame(2'd3, 2'b00, 1'b0, 8'h11, 1'b0, 2'b11);
    send_frame(2'd3, 2'b00, 1'b0, 8'h22, 1'b0, 2'b11);
    send_frame(2'd3, 2'b00, 1'b0, 8'h33, 1'b0, 2'b11);
    send_frame(2'd3, 2'b00, 1'b0, 8'h44, 1'b0, 2'b11);
    chk("ovf_no_err_yet", 32'(err_overrun), 32'd0);
    send_frame(2'd3, 2'b00, 1'b0, 8'h55, 1'b0, 2'b11);
    chk("ovf_level", 32'(rif.level), 32'd4);
    chk("ovf_err", 32'(err_overrun), 32'd1);
    chk("ovf_head", 32'(rif.rx_data), 32'h11);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(err_overrun), 32'd0);
    fork
      send_frame(2'd3, 2'b00, 1'b0, 8'h66, 1'b0, 2'b11);
      begin
        repeat (618) @(posedge clk);
        @(negedge clk);
        rif.rx_ready = 1'b1;
        @(negedge clk);
        rif.rx_ready = 1'b0;
      end
    join
    chk("full_pp_err", 32'(err_overrun), 32'd0);
    chk("full_pp_level", 32'(rif.level), 32'd4);
    chk("fifo_e0", 32'(rif.rx_data), 32'h22); pop();
    chk("fifo_e1", 32'(rif.rx_data), 32'h33); pop();
    chk("fifo_e2", 32'(rif.rx_data), 32'h44); pop();
    chk("fifo_e3", 32'(rif.rx_data), 32'h66); pop();
    chk("fifo_empty", 32'(rif.rx_valid), 32'd0);

    // reset mid-frame with one entry queued
    send_frame(2'd3, 2'b00, 1'b0, 8'h77, 1'b0, 2'b11);
    chk("rst_pre_level", 32'(rif.level), 32'd1);
    fork
      send_frame(2'd3, 2'b00, 1'b0, 8'hFF, 1'b0, 2'b11);
      begin
        repeat (300) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
      end
    join
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    chk_reset_outputs("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable UART receiver with 16x oversampling, 3-sample majority voting, selectable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and break detection. Received bytes go into a parametrised show-ahead FIFO. Each FIFO entry carries per-byte error flags. The block sits between the external RX pin and the register/bus interface, and replaces the fixed 8N1 double-buffered receiver.

## Interface
- FIFO_DEPTH, 16, entries in the receive FIFO; power of two, ≥ 2
- DIV_W, 16, width of the baud divisor
- clk  in  1  system clock
- resetn  in  1  reset: asynchronous, active-low
- rx  in  1  serial input, asynchronous to clk, idles high
- rx_en  in  1  receiver enable
- cfg_div  in  DIV_W  oversample tick period minus 1 (one tick every cfg_div+1 clocks)
- cfg_data_bits  in  2  data bits: 0→5, 1→6, 2→7, 3→8
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2  in  1  0: 1 stop bit, 1: 2 stop bits
- rx_data  out  8  head-entry data, right-aligned, unused MSBs 0
- rx_perr / rx_ferr / rx_brk  out  1 each  head-entry parity error / framing error / break
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop head when rx_valid && rx_ready
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- err_overrun  out  1  sticky; a frame was dropped because the FIFO was full
- err_clr  in  1  clears err_overrun
- busy  out  1  FSM not in IDLE

## Operation
- rx is passed through a 2-flop synchroniser that resets to 1. All sampling uses the synchronised value rs.
- Tick divider: a counter produces a one-cycle tick every cfg_div+1 clocks. The counter is forced to 0 on the cycle a start edge is detected, which aligns the oversample phase to the edge.
- Majority vote: rs is sampled on ticks 7, 8 and 9 of each bit. The bit value is majority(≥2 ones). The bit is decided on tick 9. The bit period is 16 ticks (os_cnt 0–15).
- cfg_* are latched at start detection and are stable for the whole frame. Changes mid-frame take effect on the next frame.
- States:
  - IDLE: if rx_en && rs==0, go to START, with os_cnt=0 and the tick counter reset.
  - START: at tick 9, if the vote is 1 (false start), go to IDLE. Otherwise continue to tick 15, then go to DATA.
  - DATA: LSB first. n_bits counts up to N-1. After bit N-1 at tick 15, go to PARITY if parity is enabled, else go to STOP.
  - PARITY: at tick 9 the voted bit is checked. Even: XOR(data, p) must be 0. Odd: it must be 1. A mismatch sets perr. At tick 15, go to STOP.
  - STOP: the vote at tick 9 must be 1, else ferr=1. With cfg_stop2, the first stop bit runs to tick 15 and the second is voted the same way; ferr = either stop bit low. At tick 9 of the last stop bit, push the entry and go to IDLE, or go to BRKWAIT if this is a break.
  - BRKWAIT: wait until rs==1, then go to IDLE.
- Break: all data bits 0, parity bit (if enabled) 0, and last stop bit 0. The entry is pushed with brk=1, ferr=1 and data=0.
- rx_en deasserted: the FSM goes to IDLE next cycle, the partial frame is discarded, and the FIFO and flags are kept.
- FIFO push when full: the frame is dropped and err_overrun is set. A push and a pop in the same cycle while full: both proceed and err_overrun is not set. A pop while empty is ignored.
- err_clr: clears err_overrun. If err_clr and a new overrun happen in the same cycle, err_overrun ends up set (set wins).

## Timing
- Reset values: rx_data 0, rx_perr/rx_ferr/rx_brk 0, rx_valid 0, level 0, err_overrun 0, busy 0. The FSM is in IDLE and the divider is 0.
- From rx falling to busy rising: 3 clk (2 synchroniser stages + 1 cycle detect).
- From the push decision edge to rx_valid/level update: 1 clk. rx_data and flags are valid in the same cycle as rx_valid.
- A pop updates rx_data, flags, level and rx_valid on the next clock edge. rx_valid can stay high continuously under back-to-back pops.
- The frame ends at mid last-stop-bit, so a start bit immediately following is never missed.

## Test plan
- cfg_div=3, 8N1, send 0xA5 → one entry: data 0xA5, perr/ferr/brk 0, level 1. rx_valid rises one clk after tick 9 of the stop bit.
- 7E2, send 0x3C with correct parity, then 0x3C with the parity bit flipped → entry 1 has perr=0; entry 2 has data 0x3C and perr=1.
- 5N1, send 0x1F with the stop bit low → data 0x1F, ferr=1. Then hold rx low for 2 frames → one entry with brk=1 and data 0. No further pushes until rx returns high.
- Glitch: rx low for 5 ticks then high → no entry, busy returns to 0, level unchanged.
- FIFO_DEPTH=4, send 5 bytes with rx_ready=0 → level 4, err_overrun=1, entries are bytes 1–4. err_clr → err_overrun 0. A pop coinciding with a push at full → no overrun.
- Deassert rx_en mid-DATA → no entry, busy 0 next cycle. Assert resetn low mid-frame → all outputs at reset values.
